// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyzer capture core: FSM states,
// address-width helper and the per-bit trigger evaluation.
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } la_state_t;

    function automatic int la_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Operands are zero-extended to 32 bits; unused upper bits have mask 0 and
    // therefore never block the AND reduction.
    function automatic logic la_trig_hit(
        input logic [31:0] cur,
        input logic [31:0] prev,
        input logic [31:0] mask,
        input logic [31:0] value,
        input logic [31:0] edge_sel
    );
        logic [31:0] hit;
        for (int i = 0; i < 32; i++) begin
            if (edge_sel[i])
                hit[i] = value[i] ? (~prev[i] & cur[i]) : (prev[i] & ~cur[i]);
            else
                hit[i] = (cur[i] == value[i]);
        end
        return &(~mask | hit);
    endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read
// (one cycle latency), no reset on the storage array.
module la_sample_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: circular capture with pre-trigger window,
// then oldest-first readout over AXI-Stream through a 2-entry output buffer.
module la_capture_core
    import la_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int TRIG_W = 8,
    localparam int AW    = la_aw(DEPTH)
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic [DATA_W-1:0] probe_data,
    input  logic [TRIG_W-1:0] trig_in,
    input  logic [TRIG_W-1:0] cfg_trig_mask,
    input  logic [TRIG_W-1:0] cfg_trig_value,
    input  logic [TRIG_W-1:0] cfg_trig_edge,
    input  logic [AW-1:0]     cfg_pretrig,
    input  logic              arm,
    input  logic              abort,
    output logic              st_busy,
    output logic              st_triggered,
    output logic              st_done,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH-1);

    la_state_t         r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_cnt;
    logic [AW-1:0]     r_pre_n;
    logic [AW-1:0]     r_start;
    logic [TRIG_W-1:0] r_trig_prev;
    logic              r_busy;
    logic              r_trig;
    logic              r_done;

    logic [AW:0]       r_rd_cnt;
    logic              r_rd_vld;
    logic              r_rd_last;
    logic [1:0]        r_ocnt;
    logic [DATA_W-1:0] r_o_data;
    logic              r_o_last;
    logic [DATA_W-1:0] r_s_data;
    logic              r_s_last;

    logic              w_we;
    logic              w_hit;
    logic [AW-1:0]     w_post_n;
    logic              w_pop;
    logic [1:0]        w_level;
    logic              w_issue;
    logic [AW-1:0]     w_raddr;
    logic [DATA_W-1:0] w_rdata;

    assign w_we     = (r_state == ST_PRE) || (r_state == ST_WAIT_TRIG) || (r_state == ST_POST);
    assign w_hit    = la_trig_hit(32'(trig_in), 32'(r_trig_prev), 32'(cfg_trig_mask),
                                  32'(cfg_trig_value), 32'(cfg_trig_edge));
    assign w_post_n = AW'(DEPTH-1) - r_pre_n;

    // Entries the output buffer will hold next cycle; a new read may only be
    // issued if its data still fits when it lands one cycle later.
    assign w_pop   = (r_ocnt != 2'd0) && m_axis_tready;
    assign w_level = r_ocnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
    assign w_issue = (r_state == ST_DONE) && !abort && !r_rd_cnt[AW] && (w_level <= 2'd1);
    assign w_raddr = r_start + r_rd_cnt[AW-1:0];

    la_sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .i_clk   (axi_aclk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (probe_data),
        .i_re    (w_issue),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // cfg_pretrig is AW bits wide, so it can never exceed DEPTH-1.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_pre_n     <= '0;
            r_start     <= '0;
            r_trig_prev <= '0;
            r_busy      <= 1'b0;
            r_trig      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_trig_prev <= trig_in;
            if (w_we)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_trig  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: if (arm) begin
                        r_wr_ptr <= '0;
                        r_pre_n  <= cfg_pretrig;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= (cfg_pretrig != '0) ? ST_PRE : ST_WAIT_TRIG;
                    end
                    ST_PRE: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == r_pre_n - 1'b1)
                            r_state <= ST_WAIT_TRIG;
                    end
                    ST_WAIT_TRIG: if (w_hit) begin
                        r_start <= r_wr_ptr - r_pre_n;
                        r_cnt   <= w_post_n;
                        r_trig  <= 1'b1;
                        if (w_post_n == '0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_POST;
                        end
                    end
                    ST_POST: begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == AW'(1)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    ST_DONE: if (w_pop && r_o_last) begin
                        r_state <= ST_IDLE;
                        r_trig  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Readout: r_o_* is the visible beat, r_s_* the skid entry behind it.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_rd_cnt  <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_ocnt    <= 2'd0;
            r_o_data  <= '0;
            r_o_last  <= 1'b0;
            r_s_data  <= '0;
            r_s_last  <= 1'b0;
        end else if (abort || (r_state != ST_DONE)) begin
            r_rd_cnt  <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_ocnt    <= 2'd0;
            r_o_last  <= 1'b0;
        end else begin
            r_rd_vld  <= w_issue;
            r_rd_last <= w_issue && (r_rd_cnt == LAST_IDX);
            if (w_issue)
                r_rd_cnt <= r_rd_cnt + 1'b1;
            case (r_ocnt)
                2'd0: if (r_rd_vld) begin
                    r_o_data <= w_rdata;
                    r_o_last <= r_rd_last;
                    r_ocnt   <= 2'd1;
                end
                2'd1: begin
                    if (w_pop && r_rd_vld) begin
                        r_o_data <= w_rdata;
                        r_o_last <= r_rd_last;
                    end else if (w_pop) begin
                        r_o_last <= 1'b0;
                        r_ocnt   <= 2'd0;
                    end else if (r_rd_vld) begin
                        r_s_data <= w_rdata;
                        r_s_last <= r_rd_last;
                        r_ocnt   <= 2'd2;
                    end
                end
                default: if (w_pop) begin
                    r_o_data <= r_s_data;
                    r_o_last <= r_s_last;
                    if (r_rd_vld) begin
                        r_s_data <= w_rdata;
                        r_s_last <= r_rd_last;
                    end else begin
                        r_ocnt <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign st_busy       = r_busy;
    assign st_triggered  = r_trig;
    assign st_done       = r_done;
    assign m_axis_tdata  = r_o_data;
    assign m_axis_tvalid = (r_ocnt != 2'd0);
    assign m_axis_tlast  = r_o_last;

endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
Parametrised in-fabric logic-analyzer capture engine with a configurable trigger and pre-trigger window. It records a DATA_W-wide probe bus into a circular sample buffer. After capture it streams the window, oldest sample first, over AXI-Stream. It is the successor to the vendor-inserted single-trigger probe core: it is synthesised with the design, watches internal buses such as the SPI receive path, and is read back through the existing AXIS fabric instead of JTAG.

Parameters:
DATA_W, 64, probe bus width in bits (1..256)
DEPTH, 1024, samples per capture; power of 2, at least 4; AW = log2(DEPTH)
TRIG_W, 8, trigger input width in bits (1..32)

Ports:
axi_aclk  in  1  single clock; all logic on its rising edge
axi_aresetn  in  1  asynchronous active-low reset
probe_data  in  DATA_W  bus to be sampled
trig_in  in  TRIG_W  trigger source bits
cfg_trig_mask  in  TRIG_W  1 = bit takes part in the trigger
cfg_trig_value  in  TRIG_W  level mode: required value; edge mode: 1 = rising, 0 = falling
cfg_trig_edge  in  TRIG_W  per bit: 0 = level, 1 = edge
cfg_pretrig  in  AW  samples kept before the trigger sample
arm  in  1  one-cycle pulse; starts a capture from IDLE
abort  in  1  one-cycle pulse; returns the core to IDLE from any state
st_busy  out  1  high in PRE, WAIT_TRIG and POST
st_triggered  out  1  sticky; trigger seen in the current capture
st_done  out  1  capture complete; readout pending or in progress
m_axis_tdata  out  DATA_W  readout sample
m_axis_tvalid  out  1  readout valid
m_axis_tready  in  1  readout ready
m_axis_tlast  out  1  high on the final (DEPTH-th) beat

Behaviour:
- Reset values: all outputs 0; state IDLE; pointers and counters 0; trig_prev 0.
- trig_prev <= trig_in every cycle, in every state.
- Per-bit hit: level -> trig_in == value; edge -> (value ? ~prev & cur : prev & ~cur).
- trig_hit = AND over bits of (~mask | hit). A mask of all zeros therefore means trigger immediately.
- pre_n = cfg_pretrig, latched at arm. If cfg_pretrig >= DEPTH, pre_n = DEPTH-1. Since cfg_pretrig is AW bits wide, this clamp only applies when it is widened; DEPTH-1 is always the effective maximum.
- Trigger config is sampled live, not latched.
- In PRE, WAIT_TRIG and POST, probe_data is written every cycle at wr_ptr, and wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- IDLE: arm -> PRE (pre_n > 0) or WAIT_TRIG (pre_n = 0). wr_ptr is reset to 0 on arm. The first sample is written in the cycle after arm.
- PRE: counts pre_n writes, then goes to WAIT_TRIG. A trigger during PRE is ignored.
- WAIT_TRIG: the buffer wraps freely. When trig_hit is true:
  - that cycle's sample is the trigger sample, at address T;
  - start_addr = (T - pre_n) mod DEPTH;
  - post_cnt = DEPTH-1-pre_n;
  - st_triggered is set;
  - next state is POST, or DONE if post_cnt = 0.
- POST: writes post_cnt further samples, then goes to DONE.
- DONE (readout):
  - reads DEPTH samples starting at start_addr, with wrap;
  - st_done = 1;
  - RAM has 1-cycle read latency; a 2-entry skid/output register keeps full throughput with no bubbles while tready = 1;
  - tdata and tlast hold stable while tvalid & ~tready;
  - after the last handshake (tlast & tready) the core returns to IDLE and st_done and st_triggered clear.
- Total captured window is exactly DEPTH samples: pre_n before the trigger, the trigger sample, then the rest after it.
- arm is ignored outside IDLE.
- abort wins over arm and over trig_hit in the same cycle. On abort: next cycle is IDLE, tvalid = 0, status bits clear, and the skid register is flushed.
- First-sample latency after trigger is 2 cycles from entering DONE (RAM read plus output register).

Decomposition:
- Package la_pkg holds:
  - state enum: IDLE, PRE, WAIT_TRIG, POST, DONE;
  - clog2-based AW helper;
  - trigger-hit function.
- One sub-module, la_sample_ram: simple dual-port, synchronous write and read, DATA_W x DEPTH, no reset on the array.

Test Plan:
All scenarios use DATA_W=16, DEPTH=16, TRIG_W=4, with probe_data = cycle counter starting at 0 in the cycle after arm.
- pretrig=4, level mask=F value=5; trig_in=5 when probe=20 -> 16 beats 16..31, tlast on 31, st_triggered=1 throughout DONE.
- Edge mode, mask=1 edge=1 value=1; bit0 held 1 from before arm, falls at probe=8, rises at probe=12; pretrig=2 -> trigger at 12, readout 10..25.
- pretrig=0, mask=0 -> trigger on the first WAIT_TRIG cycle (probe=0), readout 0..15.
- Scenario 1 repeated with tready toggling 1,0,0,1,... -> same 16 values in order, no duplicates or drops, tdata stable while stalled.
- Abort during POST at probe=24, then re-arm -> next cycle IDLE with tvalid=0; second capture completes correctly.
- Trigger asserted during PRE is ignored; arm pulse during DONE is ignored; trig_hit and abort in the same cycle -> IDLE.
